base_ram_uart_ctrl: RTL and testbench

Sequences the CPU data port onto the shared BaseRAM bus, whose low 8 data bits are also wired to the CPLD UART controller.
Decodes two fixed UART addresses and routes those accesses to the CPLD rdn/wrn handshake. All other addresses go to BaseRAM as multi-cycle SRAM reads and writes.
Stalls the CPU with busy/ack. Sits between the CPU data port and the top-level BaseRAM/UART pins; the top level instantiates the tri-state buffer.

---
 rtl/cpu_defs.sv | 27 ++
 rtl/base_ram_uart_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_base_ram_uart_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the CPU data-port bridge onto the BaseRAM/UART bus.
package cpu_defs;

    typedef enum logic [3:0] {
        IDLE,
        SRAM_RD,
        SRAM_WR,
        SRAM_WR_HOLD,
        UART_RD,
        UART_WR,
        UART_WR_WAIT,
        STAT,
        DONE
    } state_t;

    localparam logic [31:0] UART_DATA_ADDR_DEFAULT = 32'hBFD0_03F8;
    localparam logic [31:0] UART_STAT_ADDR_DEFAULT = 32'hBFD0_03FC;

    // Largest of three cycle counts; sizes the shared timing counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/base_ram_uart_ctrl.sv
// CPU data-port sequencer for the shared BaseRAM bus and the CPLD UART behind it.
// Every bus-facing output is registered from its next-state value.
module base_ram_uart_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned RD_CYCLES      = 2,
    parameter int unsigned WR_CYCLES      = 2,
    parameter int unsigned UART_PULSE     = 2,
    parameter logic [31:0] UART_DATA_ADDR = UART_DATA_ADDR_DEFAULT,
    parameter logic [31:0] UART_STAT_ADDR = UART_STAT_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be_n,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic [19:0] ram_addr,
    output logic [31:0] ram_data_o,
    output logic        ram_data_oe,
    input  logic [31:0] ram_data_i,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    output logic [3:0]  ram_be_n,
    output logic        uart_rdn,
    output logic        uart_wrn,
    input  logic        uart_dataready,
    input  logic        uart_tbre,
    input  logic        uart_tsre
);

    localparam int unsigned CNT_MAX = max3(RD_CYCLES, WR_CYCLES, UART_PULSE);
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);
    localparam logic [CW-1:0] WR_LAST = CW'(WR_CYCLES - 1);
    localparam logic [CW-1:0] UP_LAST = CW'(UART_PULSE - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [19:0]   ram_addr_q, ram_addr_d;
    logic [31:0]   ram_data_o_q, ram_data_o_d;
    logic [3:0]    be_q, be_d;
    logic          tbre_seen_q, tbre_seen_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ce_n_q, ce_n_d;
    logic          oe_n_q, oe_n_d;
    logic          we_n_q, we_n_d;
    logic [3:0]    ram_be_n_q, ram_be_n_d;
    logic          ram_data_oe_q, ram_data_oe_d;
    logic          rdn_q, rdn_d;
    logic          wrn_q, wrn_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;

    // Next-state, request latching, read-data capture and the per-state timing counter.
    always_comb begin
        state_d      = state_q;
        ram_addr_d   = ram_addr_q;
        ram_data_o_d = ram_data_o_q;
        be_d         = be_q;
        tbre_seen_d  = tbre_seen_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    ram_addr_d   = addr[21:2];
                    ram_data_o_d = wdata;
                    be_d         = be_n;
                    tbre_seen_d  = 1'b0;
                    if (addr == UART_DATA_ADDR) begin
                        if (we) begin
                            state_d = UART_WR;
                        end else if (uart_dataready) begin
                            state_d = UART_RD;
                        end else begin
                            // Nothing waiting in the UART: answer zero without a strobe.
                            rdata_d = '0;
                            state_d = DONE;
                        end
                    end else if (addr == UART_STAT_ADDR) begin
                        if (!we) begin
                            rdata_d = {30'b0, uart_dataready, uart_tbre & uart_tsre};
                        end
                        state_d = STAT;
                    end else begin
                        state_d = we ? SRAM_WR : SRAM_RD;
                    end
                end
            end
            SRAM_RD: begin
                if (cnt_q == RD_LAST) begin
                    rdata_d = ram_data_i;
                    state_d = DONE;
                end
            end
            SRAM_WR: begin
                if (cnt_q == WR_LAST) begin
                    state_d = SRAM_WR_HOLD;
                end
            end
            SRAM_WR_HOLD: state_d = DONE;
            UART_RD: begin
                if (cnt_q == UP_LAST) begin
                    rdata_d = {24'b0, ram_data_i[7:0]};
                    state_d = DONE;
                end
            end
            UART_WR: begin
                if (cnt_q == UP_LAST) begin
                    state_d = UART_WR_WAIT;
                end
            end
            UART_WR_WAIT: begin
                // Holding register must empty before the shift register is checked.
                if (uart_tbre) begin
                    tbre_seen_d = 1'b1;
                end
                if (uart_tsre && (tbre_seen_q || uart_tbre)) begin
                    state_d = DONE;
                end
            end
            STAT:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d == state_q) ? cnt_q + CW'(1) : '0;
    end

    // Bus strobes and handshake decoded from the state being entered, so they register cleanly.
    always_comb begin
        ce_n_d        = 1'b1;
        oe_n_d        = 1'b1;
        we_n_d        = 1'b1;
        ram_be_n_d    = 4'hF;
        ram_data_oe_d = 1'b0;
        rdn_d         = 1'b1;
        wrn_d         = 1'b1;
        ack_d         = (state_d == DONE);
        busy_d        = (state_d != IDLE);
        case (state_d)
            SRAM_RD: begin
                ce_n_d     = 1'b0;
                oe_n_d     = 1'b0;
                ram_be_n_d = 4'h0;
            end
            SRAM_WR: begin
                ce_n_d        = 1'b0;
                we_n_d        = 1'b0;
                ram_be_n_d    = be_d;
                ram_data_oe_d = 1'b1;
            end
            SRAM_WR_HOLD: begin
                ce_n_d        = 1'b0;
                ram_be_n_d    = be_d;
                ram_data_oe_d = 1'b1;
            end
            UART_RD: rdn_d = 1'b0;
            UART_WR: begin
                wrn_d         = 1'b0;
                ram_data_oe_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State and output registers; reset drops every strobe on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            ram_addr_q    <= '0;
            ram_data_o_q  <= '0;
            be_q          <= 4'hF;
            tbre_seen_q   <= 1'b0;
            rdata_q       <= '0;
            ce_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            we_n_q        <= 1'b1;
            ram_be_n_q    <= 4'hF;
            ram_data_oe_q <= 1'b0;
            rdn_q         <= 1'b1;
            wrn_q         <= 1'b1;
            ack_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_o_q  <= ram_data_o_d;
            be_q          <= be_d;
            tbre_seen_q   <= tbre_seen_d;
            rdata_q       <= rdata_d;
            ce_n_q        <= ce_n_d;
            oe_n_q        <= oe_n_d;
            we_n_q        <= we_n_d;
            ram_be_n_q    <= ram_be_n_d;
            ram_data_oe_q <= ram_data_oe_d;
            rdn_q         <= rdn_d;
            wrn_q         <= wrn_d;
            ack_q         <= ack_d;
            busy_q        <= busy_d;
        end
    end

    assign rdata       = rdata_q;
    assign ack         = ack_q;
    assign busy        = busy_q;
    assign ram_addr    = ram_addr_q;
    assign ram_data_o  = ram_data_o_q;
    assign ram_data_oe = ram_data_oe_q;
    assign ram_ce_n    = ce_n_q;
    assign ram_oe_n    = oe_n_q;
    assign ram_we_n    = we_n_q;
    assign ram_be_n    = ram_be_n_q;
    assign uart_rdn    = rdn_q;
    assign uart_wrn    = wrn_q;

endmodule

// File: tb/tb_base_ram_uart_ctrl.sv
// Transaction-level bench: each access is expanded into a per-cycle list of expected
// bus outputs from its timing rules, and a negedge process compares the DUT to it.
module tb_base_ram_uart_ctrl;

    localparam int RD = 2;
    localparam int WR = 2;
    localparam int UP = 2;
    localparam logic [31:0] UD = 32'hBFD0_03F8;
    localparam logic [31:0] US = 32'hBFD0_03FC;

    logic        clk = 1'b0;
    logic        rst, req, we;
    logic [31:0] addr, wdata, rdata, ram_data_o, ram_data_i;
    logic [3:0]  be_n, ram_be_n;
    logic        ack, busy, ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n;
    logic [19:0] ram_addr;
    logic        uart_rdn, uart_wrn, uart_dataready, uart_tbre, uart_tsre;

    always #5 clk = ~clk;

    base_ram_uart_ctrl #(
        .RD_CYCLES(RD), .WR_CYCLES(WR), .UART_PULSE(UP),
        .UART_DATA_ADDR(UD), .UART_STAT_ADDR(US)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .be_n(be_n), .rdata(rdata), .ack(ack), .busy(busy), .ram_addr(ram_addr),
        .ram_data_o(ram_data_o), .ram_data_oe(ram_data_oe), .ram_data_i(ram_data_i),
        .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
        .ram_be_n(ram_be_n), .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
        .uart_dataready(uart_dataready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
    );

    // ctl = {ce_n, oe_n, we_n, rdn, wrn, data_oe, ack, busy}
    typedef struct {
        logic [7:0]  ctl;
        logic [3:0]  be;
        logic [19:0] raddr;
        bit          chk_rd;
        logic [31:0] rd;
        int          chk_d;   // 0 none, 1 full word, 2 low byte
        logic [31:0] dout;
        int          k;       // cycle index within transaction, -1 outside
    } exp_t;

    exp_t        exp_q[$];
    exp_t        ce;
    logic [19:0] cur_raddr = '0;
    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;
    int obs_ce_lo, obs_oe_lo, obs_we_lo, obs_rdn_lo, obs_wrn_lo, obs_doe_hi;
    int obs_ack_cnt, obs_ack_k;
    logic [31:0] obs_ack_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, expv, $time);
        end
    endtask

    // Compare DUT outputs with the expectation list once per cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            ce = exp_q.pop_front();
            if (ce.k == 0) begin
                obs_ce_lo = 0; obs_oe_lo = 0; obs_we_lo = 0; obs_rdn_lo = 0;
                obs_wrn_lo = 0; obs_doe_hi = 0; obs_ack_cnt = 0; obs_ack_k = -1;
                obs_ack_rd = '0;
            end
            check("ctl", {24'b0, ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn,
                          ram_data_oe, ack, busy}, {24'b0, ce.ctl});
            check("ram_be_n", {28'b0, ram_be_n}, {28'b0, ce.be});
            check("ram_addr", {12'b0, ram_addr}, {12'b0, ce.raddr});
            check("no_contention", {31'b0, ram_data_oe & (~ram_oe_n | ~uart_rdn)}, 32'h0);
            if (ce.chk_rd) check("rdata", rdata, ce.rd);
            if (ce.chk_d == 1) check("ram_data_o", ram_data_o, ce.dout);
            else if (ce.chk_d == 2) check("uart_wdata", {24'b0, ram_data_o[7:0]}, ce.dout);
            if (ce.k >= 0) begin
                if (!ram_ce_n) obs_ce_lo++;
                if (!ram_oe_n) obs_oe_lo++;
                if (!ram_we_n) obs_we_lo++;
                if (!uart_rdn) obs_rdn_lo++;
                if (!uart_wrn) obs_wrn_lo++;
                if (ram_data_oe) obs_doe_hi++;
                if (ack) begin
                    obs_ack_cnt++;
                    obs_ack_k  = ce.k;
                    obs_ack_rd = rdata;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        ram_data_i     = $urandom;
        uart_dataready = 1'($urandom);
        uart_tbre      = 1'($urandom);
        uart_tsre      = 1'($urandom);
    endtask

    function automatic exp_t quiet_exp(input logic [19:0] ra, input bit rst_state);
        exp_t e;
        e.ctl = 8'b1111_1000; e.be = 4'hF; e.raddr = ra;
        e.chk_rd = rst_state; e.rd = '0; e.chk_d = 0; e.dout = '0; e.k = -1;
        return e;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            rst = 1'b1; req = 1'b0; we = 1'($urandom); addr = $urandom;
            wdata = $urandom; be_n = 4'($urandom);
            rand_inputs();
            exp_q.push_back(quiet_exp(cur_raddr, 1'b0));
        end
    endtask

    // One CPU access. The model expands it into per-cycle expectations.
    task automatic txn(input bit we_i, input logic [31:0] addr_i, input logic [31:0] wd,
                       input logic [3:0] be_i, input bit dr_i, input bit st_tb, input bit st_ts,
                       input int a, input int b, input bit noise,
                       input bit use_fix, input logic [31:0] fix, input bit rst_mid);
        int kind, len, wdone, w;
        bit seen;
        bit tb_a[$];
        bit ts_a[$];
        logic [31:0] saved;
        logic [19:0] na;
        exp_t e;
        if (addr_i == UD) kind = we_i ? 4 : (dr_i ? 2 : 3);
        else if (addr_i == US) kind = 5;
        else kind = we_i ? 1 : 0;
        wdone = 0;
        if (kind == 4) begin
            for (int i = 0; i <= a + b; i++) begin
                tb_a.push_back(i >= a);
                ts_a.push_back((i >= a + b) ? 1'b1 : ((i < a && noise) ? 1'($urandom) : 1'b0));
            end
            seen = 0;
            for (int i = 0; i < tb_a.size(); i++) begin
                seen = seen | tb_a[i];
                if (ts_a[i] && seen) begin wdone = i; break; end
            end
        end
        case (kind)
            0: len = RD + 1;
            1: len = WR + 2;
            2: len = UP + 1;
            3: len = 1;
            4: len = UP + wdone + 2;
            default: len = 2;
        endcase
        saved = '0;
        na = addr_i[21:2];
        next_cycle();
        rst = 1'b1; req = 1'b1; we = we_i; addr = addr_i; wdata = wd; be_n = be_i;
        uart_dataready = dr_i; uart_tbre = st_tb; uart_tsre = st_ts;
        ram_data_i = use_fix ? fix : $urandom;
        e = quiet_exp(cur_raddr, 1'b0);
        e.k = 0;
        exp_q.push_back(e);
        for (int k = 1; k <= len; k++) begin
            next_cycle();
            rand_inputs();
            if (use_fix) ram_data_i = fix;
            if (kind == 4 && k > UP) begin
                w = k - UP - 1;
                if (w <= wdone) begin uart_tbre = tb_a[w]; uart_tsre = ts_a[w]; end
            end
            if (rst_mid && k == 2) begin
                rst = 1'b0; req = 1'b0;
                e = quiet_exp(20'h0, 1'b1);
                e.k = k;
                exp_q.push_back(e);
                cur_raddr = '0;
                $display("txn %0d: write 0x%08h aborted by reset", n_txn, addr_i);
                n_txn++;
                return;
            end
            if (rst_mid && k == 1) rst = 1'b0;
            e = quiet_exp(na, 1'b0);
            e.ctl = 8'b1111_1001;
            e.k = k;
            case (kind)
                0: if (k <= RD) begin
                    e.ctl = 8'b0011_1001; e.be = 4'h0;
                    if (k == RD) saved = ram_data_i;
                end
                1: if (k <= WR) begin
                    e.ctl = 8'b0101_1101; e.be = be_i; e.chk_d = 1; e.dout = wd;
                end else if (k == WR + 1) begin
                    e.ctl = 8'b0111_1101; e.be = be_i; e.chk_d = 1; e.dout = wd;
                end
                2: if (k <= UP) begin
                    e.ctl = 8'b1110_1001;
                    if (k == UP) saved = {24'b0, ram_data_i[7:0]};
                end
                4: if (k <= UP) begin
                    e.ctl = 8'b1111_0101; e.chk_d = 2; e.dout = {24'b0, wd[7:0]};
                end
                default: ;
            endcase
            if (k == len) begin
                e.ctl = 8'b1111_1011;
                if (kind == 0 || kind == 2 || kind == 3) begin e.chk_rd = 1; e.rd = saved; end
                if (kind == 5 && !we_i) begin
                    e.chk_rd = 1; e.rd = {30'b0, dr_i, st_tb & st_ts};
                end
            end
            exp_q.push_back(e);
        end
        cur_raddr = na;
        $display("txn %0d: kind=%0d we=%0d addr=0x%08h ack_cycle=%0d", n_txn, kind, we_i, addr_i, len);
        n_txn++;
    endtask

    initial begin
        int kind_r, gap;
        logic [31:0] ra;
        rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be_n = 4'hF;
        ram_data_i = '0; uart_dataready = 1'b0; uart_tbre = 1'b0; uart_tsre = 1'b0;
        obs_ack_k = -1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            rst = 1'b0; req = 1'b1; we = 1'($urandom); addr = $urandom; wdata = $urandom;
            rand_inputs();
            exp_q.push_back(quiet_exp(20'h0, 1'b1));
        end
        next_cycle();
        rst = 1'b1; req = 1'b0;
        exp_q.push_back(quiet_exp(20'h0, 1'b1));
        settle();
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_ack", {31'b0, ack}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_strobes", {27'b0, ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn}, 32'h1F);
        check("reset_be_oe", {27'b0, ram_be_n, ram_data_oe}, 32'h1E);
        idle(1);

        txn(0, 32'h8000_0010, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678, 0);
        settle();
        check("lit_rd_ack_cycle", 32'(obs_ack_k), 32'd3);
        check("lit_rd_rdata", obs_ack_rd, 32'h1234_5678);
        check("lit_rd_oe_low", 32'(obs_oe_lo), 32'd2);
        check("lit_rd_addr", {12'b0, ram_addr}, 32'h4);

        txn(1, 32'h8000_0020, 32'hDEAD_BEEF, 4'b1110, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        settle();
        check("lit_wr_we_low", 32'(obs_we_lo), 32'd2);
        check("lit_wr_oe_high", 32'(obs_doe_hi), 32'd3);
        check("lit_wr_ack_cycle", 32'(obs_ack_k), 32'd4);

        txn(1, UD, 32'h41, 4'h0, 0, 0, 0, 5, 3, 0, 0, 32'h0, 0);
        settle();
        check("lit_uwr_wrn_low", 32'(obs_wrn_lo), 32'd2);
        check("lit_uwr_ce_low", 32'(obs_ce_lo), 32'd0);
        check("lit_uwr_ack_cycle", 32'(obs_ack_k), 32'd12);

        txn(0, UD, 32'h0, 4'h0, 1, 0, 0, 0, 0, 0, 1, 32'hA5A5_A55A, 0);
        settle();
        check("lit_urd_rdata", obs_ack_rd, 32'h0000_005A);
        check("lit_urd_rdn_low", 32'(obs_rdn_lo), 32'd2);

        txn(0, UD, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0);
        settle();
        check("lit_urd_empty_ack", 32'(obs_ack_k), 32'd1);
        check("lit_urd_empty_rdata", obs_ack_rd, 32'h0);
        check("lit_urd_empty_rdn", 32'(obs_rdn_lo), 32'd0);

        txn(0, US, 32'h0, 4'h0, 1, 1, 0, 0, 0, 0, 0, 32'h0, 0);
        settle();
        check("lit_stat_rdata", obs_ack_rd, 32'h2);

        txn(1, US, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        settle();
        check("lit_statwr_acked", 32'(obs_ack_cnt), 32'd1);
        check("lit_statwr_strobes", 32'(obs_ce_lo + obs_rdn_lo + obs_wrn_lo + obs_doe_hi), 32'd0);

        txn(1, 32'h8000_0100, 32'h1357_9BDF, 4'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
        settle();
        check("lit_abort_no_ack", 32'(obs_ack_cnt), 32'd0);
        check("lit_abort_busy", {31'b0, busy}, 32'h0);
        txn(0, 32'h8000_0040, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 0);
        settle();
        check("lit_after_abort_rdata", obs_ack_rd, 32'hCAFE_F00D);
        check("lit_after_abort_ack", 32'(obs_ack_k), 32'd3);

        for (int i = 0; i < 200; i++) begin
            gap = $urandom_range(0, 2);
            if (gap != 0) idle(gap);
            kind_r = $urandom_range(0, 5);
            ra = 32'h8000_0000 | ($urandom & 32'h003F_FFFF);
            case (kind_r)
                0, 1: txn(kind_r == 1, ra, $urandom, 4'($urandom), 1'($urandom),
                          0, 0, 0, 0, 0, 0, 32'h0, 0);
                2: txn(0, UD, $urandom, 4'($urandom), 1'($urandom), 0, 0, 0, 0, 0, 0, 32'h0, 0);
                3: txn(1, UD, $urandom, 4'($urandom), 1'($urandom), 0, 0,
                       $urandom_range(0, 4), $urandom_range(1, 4), 1, 0, 32'h0, 0);
                default: txn(1'($urandom), US, $urandom, 4'($urandom), 1'($urandom),
                             1'($urandom), 1'($urandom), 0, 0, 0, 0, 32'h0, 0);
            endcase
        end
        idle(3);
        settle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
